// File: rtl/noc_xbar_arbiter.sv
// Five-output round-robin crossbar arbiter with per-output owner tracking.
// Optional forced release of long ownerships is enabled by defining ARB_TIMEOUT_EN.
module noc_xbar_arbiter #(
  parameter int unsigned NPORT   = 5,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [24:0] req,
  output logic [24:0] grant,
  output logic [14:0] owner,
  output logic [4:0]  busy,
  output logic        err,
  output logic        timeout
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state_q [NPORT];
  state_t     state_d [NPORT];
  logic [2:0] own_q   [NPORT];
  logic [2:0] own_d   [NPORT];
  logic [2:0] ptr_q   [NPORT];
  logic [2:0] ptr_d   [NPORT];
  logic [4:0] onehot;
  logic [4:0] multi;
  logic       err_d;
  logic       timeout_d;
  logic       found;
  logic       hold;
  logic       rel;
  int unsigned idx;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt_q [NPORT];
  logic [7:0] cnt_d [NPORT];
`endif

  if (TIMEOUT == 0 || TIMEOUT > 255) begin : g_bad_timeout
    $error("TIMEOUT must be in 1..255");
  end

  always_comb begin
    onehot = '0;
    multi  = '0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      onehot[i] = (req[5*i +: 5] != 5'd0) &&
                  ((req[5*i +: 5] & (req[5*i +: 5] - 5'd1)) == 5'd0);
      multi[i]  = (req[5*i +: 5] != 5'd0) && !onehot[i];
    end
  end

  always_comb begin
    err_d     = err | (|multi);
    timeout_d = timeout;
    found     = 1'b0;
    hold      = 1'b0;
    rel       = 1'b0;
    idx       = 0;
    for (int unsigned j = 0; j < NPORT; j++) begin
      state_d[j] = state_q[j];
      own_d[j]   = own_q[j];
      ptr_d[j]   = ptr_q[j];
`ifdef ARB_TIMEOUT_EN
      cnt_d[j]   = cnt_q[j];
`endif
      if (state_q[j] == IDLE) begin
        // Scan from the pointer; only well-formed one-hot requesters compete.
        found = 1'b0;
        for (int unsigned k = 0; k < NPORT; k++) begin
          idx = (32'(ptr_q[j]) + k) % NPORT;
          if (!found && onehot[idx] && req[5*idx + j]) begin
            found      = 1'b1;
            state_d[j] = BUSY;
            own_d[j]   = idx[2:0];
`ifdef ARB_TIMEOUT_EN
            cnt_d[j]   = '0;
`endif
          end
        end
      end else begin
        hold = 1'b0;
        for (int unsigned i = 0; i < NPORT; i++)
          if (own_q[j] == 3'(i)) hold = onehot[i] && req[5*i + j];
        rel = !hold;
`ifdef ARB_TIMEOUT_EN
        cnt_d[j] = cnt_q[j] + 8'd1;
        if (hold && (cnt_q[j] + 8'd1 == 8'(TIMEOUT))) begin
          rel       = 1'b1;
          timeout_d = 1'b1;
        end
`endif
        if (rel) begin
          state_d[j] = IDLE;
          own_d[j]   = 3'b111;
          ptr_d[j]   = (own_q[j] == 3'd4) ? 3'd0 : own_q[j] + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned j = 0; j < NPORT; j++) begin
        state_q[j] <= IDLE;
        own_q[j]   <= 3'b111;
        ptr_q[j]   <= '0;
`ifdef ARB_TIMEOUT_EN
        cnt_q[j]   <= '0;
`endif
      end
      err     <= 1'b0;
      timeout <= 1'b0;
    end else begin
      for (int unsigned j = 0; j < NPORT; j++) begin
        state_q[j] <= state_d[j];
        own_q[j]   <= own_d[j];
        ptr_q[j]   <= ptr_d[j];
`ifdef ARB_TIMEOUT_EN
        cnt_q[j]   <= cnt_d[j];
`endif
      end
      err <= err_d;
`ifdef ARB_TIMEOUT_EN
      timeout <= timeout_d;
`else
      timeout <= 1'b0;
`endif
    end
  end

  // Outputs derive only from registered ownership, never from req.
  always_comb begin
    grant = '0;
    owner = '1;
    busy  = '0;
    for (int unsigned j = 0; j < NPORT; j++) begin
      busy[j]         = (state_q[j] == BUSY);
      owner[3*j +: 3] = own_q[j];
      for (int unsigned i = 0; i < NPORT; i++)
        if (state_q[j] == BUSY && own_q[j] == 3'(i)) grant[5*i + j] = 1'b1;
    end
  end

endmodule
